// File: rtl/i2c_bus_monitor.sv
// I2C bus-state monitor: per-line glitch filters, START/rSTART/STOP detection,
// tBUF hold-off before the bus is declared free, and SCL stuck-low detection.

module i2c_glitch_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic n_rst,
  input  logic raw,
  output logic filt
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [CW-1:0] cnt;

  // filt only follows raw once the new level has been seen FILTER_LEN edges in a row
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      filt <= 1'b1;
      cnt  <= '0;
    end else if (raw == filt) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      filt <= raw;
      cnt  <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
endmodule

module i2c_bus_monitor #(
  parameter int FILTER_LEN   = 4,
  parameter int TBUF_CYCLES  = 20,
  parameter int STUCK_CYCLES = 1000
) (
  input  logic clk,
  input  logic n_rst,
  input  logic SDA_sync,
  input  logic SCL_sync,
  output logic bus_busy,
  output logic bus_free,
  output logic start_det,
  output logic rstart_det,
  output logic stop_det,
  output logic scl_stuck
);
  localparam int TW = $clog2(TBUF_CYCLES + 1);
  localparam logic [TW-1:0] TBUF_LAST = TW'(TBUF_CYCLES - 1);

  typedef enum logic [1:0] {HOLDOFF, IDLE, BUSY} state_t;

  // lane 1 = SCL, lane 0 = SDA
  logic [1:0] raw, filt;
  logic       scl_f, sda_f, scl_d, sda_d;
  logic       start_cond, stop_cond;

  state_t          state, state_nxt;
  logic [TW-1:0]   tbuf_cnt, tbuf_nxt;
  logic            start_nxt, rstart_nxt, stop_nxt;

  assign raw = {SCL_sync, SDA_sync};

  i2c_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt [1:0] (
    .clk  (clk),
    .n_rst(n_rst),
    .raw  (raw),
    .filt (filt)
  );

  assign scl_f = filt[1];
  assign sda_f = filt[0];

  // SCL must be stable high across both samples, so simultaneous edges raise nothing
  assign start_cond = scl_d & scl_f & sda_d & !sda_f;
  assign stop_cond  = scl_d & scl_f & !sda_d & sda_f;

  always_comb begin
    state_nxt  = state;
    tbuf_nxt   = '0;
    start_nxt  = 1'b0;
    rstart_nxt = 1'b0;
    stop_nxt   = 1'b0;
    case (state)
      HOLDOFF: begin
        if (start_cond) begin
          state_nxt = BUSY;
          start_nxt = 1'b1;
        end else if (!scl_f) begin
          state_nxt = BUSY;
        end else if (sda_f) begin
          if (tbuf_cnt == TBUF_LAST) state_nxt = IDLE;
          else                       tbuf_nxt  = tbuf_cnt + TW'(1);
        end
      end
      IDLE: begin
        if (start_cond) begin
          state_nxt = BUSY;
          start_nxt = 1'b1;
        end else if (!scl_f) begin
          state_nxt = BUSY;
        end else if (stop_cond) begin
          stop_nxt = 1'b1;
        end
      end
      BUSY: begin
        if (start_cond) begin
          rstart_nxt = 1'b1;
        end else if (stop_cond) begin
          state_nxt = HOLDOFF;
          stop_nxt  = 1'b1;
        end
      end
      default: state_nxt = HOLDOFF;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= HOLDOFF;
      tbuf_cnt   <= '0;
      scl_d      <= 1'b1;
      sda_d      <= 1'b1;
      bus_busy   <= 1'b0;
      bus_free   <= 1'b0;
      start_det  <= 1'b0;
      rstart_det <= 1'b0;
      stop_det   <= 1'b0;
    end else begin
      state      <= state_nxt;
      tbuf_cnt   <= tbuf_nxt;
      scl_d      <= scl_f;
      sda_d      <= sda_f;
      bus_busy   <= (state_nxt == BUSY);
      bus_free   <= (state_nxt == IDLE);
      start_det  <= start_nxt;
      rstart_det <= rstart_nxt;
      stop_det   <= stop_nxt;
    end
  end

  generate
    if (STUCK_CYCLES == 0) begin : g_no_stuck
      assign scl_stuck = 1'b0;
    end else begin : g_stuck
      localparam int SW = $clog2(STUCK_CYCLES + 1);
      localparam logic [SW-1:0] STUCK_MAX = SW'(STUCK_CYCLES);
      logic [SW-1:0] stuck_cnt;

      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)                      stuck_cnt <= '0;
        else if (scl_f)                  stuck_cnt <= '0;
        else if (stuck_cnt != STUCK_MAX) stuck_cnt <= stuck_cnt + SW'(1);
      end

      assign scl_stuck = (stuck_cnt == STUCK_MAX);
    end
  endgenerate
endmodule

// File: doc/i2c_bus_monitor.md
# i2c_bus_monitor

Parametrised I2C bus-state monitor for the APB I2C master. Per-line glitch filtering on the synchronised SCL/SDA inputs, registered START/repeated-START/STOP pulses, a bus-free hold-off (tBUF), conservative late-attach handling and SCL stuck-low detection. The master's arbitration and start logic use it to decide when the bus may be claimed.

## Interface
- FILTER_LEN, 4: consecutive cycles a raw level must hold before the filtered line follows it (≥1).
- TBUF_CYCLES, 20: cycles both filtered lines must be high after STOP or reset before bus_free asserts (≥1).
- STUCK_CYCLES, 1000: cycles of filtered SCL low before scl_stuck asserts; 0 disables detection.
- clk  in  1  system clock.
- n_rst  in  1  reset, asynchronous, active-low; clock clk.
- SDA_sync  in  1  SDA, already synchronised to clk.
- SCL_sync  in  1  SCL, already synchronised to clk.
- bus_busy  out  1  transaction in progress (registered).
- bus_free  out  1  bus idle and tBUF satisfied (registered).
- start_det  out  1  one-cycle pulse, START from non-busy state.
- rstart_det  out  1  one-cycle pulse, repeated START while busy.
- stop_det  out  1  one-cycle pulse, STOP seen.
- scl_stuck  out  1  SCL held low ≥ STUCK_CYCLES (level).

## Operation
- Filter, per line: registers filt (reset 1) and cnt ($clog2(FILTER_LEN+1) bits, reset 0). If raw == filt, cnt <= 0. Otherwise cnt increments. On the edge where cnt == FILTER_LEN-1 and raw != filt, filt <= raw and cnt <= 0. With FILTER_LEN=1, filt simply follows raw one edge later.
- Previous-value registers scl_d/sda_d (reset 1) hold last cycle's filt.
- START condition: scl_d & scl_f & sda_d & !sda_f. STOP condition: scl_d & scl_f & !sda_d & sda_f.
- If SCL and SDA change on the same cycle, no condition is raised.
- FSM states: HOLDOFF (reset), IDLE, BUSY.
  - HOLDOFF: START → BUSY and pulse start_det. Otherwise !scl_f → BUSY with no pulse (late attach). Otherwise, if both lines are high, tbuf_cnt increments; when it reaches TBUF_CYCLES-1, go to IDLE. tbuf_cnt clears whenever sda_f is low.
  - IDLE: START → BUSY, pulse start_det. !scl_f without START → BUSY, no pulse. STOP → stay, pulse stop_det.
  - BUSY: START → stay, pulse rstart_det. STOP → HOLDOFF, tbuf_cnt <= 0, pulse stop_det.
- Outputs: bus_busy = (state==BUSY), bus_free = (state==IDLE). Both are registered with the state. In HOLDOFF both are 0.
- Stuck counter (width $clog2(STUCK_CYCLES+1)):
  - Increments while !scl_f and saturates at STUCK_CYCLES.
  - scl_stuck = (count == STUCK_CYCLES).
  - Clears on the edge after scl_f is sampled high.
  - Independent of the FSM state.
- All counters saturate; none wrap.

## Timing
- Reset values: bus_busy 0, bus_free 0, start_det 0, rstart_det 0, stop_det 0, scl_stuck 0. State HOLDOFF, filters 1, all counters 0.
- Reset asserted mid-transaction: all outputs drop immediately (async). After release, bus_free needs TBUF_CYCLES high cycles plus filter latency.
- Latency: edge 1 is the first edge sampling the new raw level. Filt updates at edge FILTER_LEN. State, bus_busy, bus_free and the *_det pulses update at edge FILTER_LEN+1.
- Glitch rule: a raw pulse shorter than FILTER_LEN cycles never reaches filt.
- Pulses are exactly one cycle wide. Only one of start_det, rstart_det, stop_det is high in any cycle.
- bus_free rises TBUF_CYCLES edges after entering HOLDOFF with both lines steady high.
- scl_stuck rises STUCK_CYCLES edges after scl_f falls. It falls one edge after scl_f rises.

## Test plan
- Defaults, both lines high from reset: after 20 cycles bus_free=1. Then SDA falls with SCL high → start_det pulse and bus_busy=1 exactly 5 edges after the first sample of SDA low; bus_free=0 on the same edge.
- Defaults, BUSY: SDA low→high with SCL high → stop_det pulse, bus_busy=0, bus_free=0. bus_free=1 20 edges later. A START at hold-off cycle 10 → start_det, BUSY, bus_free never asserts.
- Defaults, BUSY, SCL low, SDA high, then SCL high, then SDA falls (repeated START) → rstart_det pulse, start_det stays 0, bus_busy stays 1.
- Defaults, IDLE, 3-cycle SDA low glitch with SCL high → no pulses, state unchanged. The same test with a 4-cycle glitch → start_det.
- STUCK_CYCLES=8, SCL held low 20 cycles → scl_stuck=1 from the 8th edge after scl_f falls and bus_busy=1. Release SCL → scl_stuck=0 one edge after scl_f rises.
- Mid-transaction n_rst pulse → all outputs 0 asynchronously. After release with SCL toggling → bus_busy=1 (late attach) with no start_det.
